stage4_memory_sequencer: RTL and testbench
==========================================

# stage4_memory_sequencer

Sequences data-memory accesses for the load/store path between stage 3 (address/data generation) and stage 4 (memory result routing). It accepts one load or store per request, checks alignment and size, drives a single-outstanding req/done handshake to the data cache, and stalls the pipeline until the access completes. For loads, it hands stage 4 a lane-aligned read word. Stage 4 then sign- or zero-extends that word into `memory_data_i`.

## Interface
- `TIMEOUT_CYCLES`, default 1024: cycles `mem_req_o` may stay high without `mem_done_i` before a bus error is raised; minimum 2.

Ports:
- `clock_i`  in  1  system clock; all state updates on rising edge
- `reset_i`  in  1  synchronous, active-high reset
- `req_i`  in  1  stage 3 presents a memory op this cycle
- `wren_i`  in  1  1 = store, 0 = load
- `func3_i`  in  3  size code; bits[1:0] select 0 = byte, 1 = half, 2 = word, 3 = illegal
- `addr_i`  in  32  byte address
- `wdata_i`  in  32  store data, value in low lanes
- `flush_i`  in  1  pipeline flush; discard current/pending op
- `mem_req_o`  out  1  request to cache, held until done
- `mem_wren_o`  out  1  store qualifier
- `mem_addr_o`  out  32  word address, `{addr_i[31:2],2'b00}`
- `mem_wdata_o`  out  32  store data shifted left by 8×`addr_i[1:0]`
- `mem_ben_o`  out  4  byte enables
- `mem_done_i`  in  1  cache completion, one-cycle pulse
- `mem_rdata_i`  in  32  read word, valid with `mem_done_i`
- `stall_o`  out  1  freeze upstream stages
- `rdata_o`  out  32  read word shifted right by 8×`addr[1:0]`
- `rdata_valid_o`  out  1  one-cycle pulse, load result valid
- `misaligned_o`  out  1  pulse: half with `addr[0]`=1, or word with `addr[1:0]`≠0
- `illegal_o`  out  1  pulse: `func3_i[1:0]`==3
- `bus_error_o`  out  1  pulse: timeout expired

## Operation
- States:
  - IDLE: no access in progress.
  - BUSY: request outstanding.
  - RESP: completed load/store presented for one cycle.
  - DRAIN: flushed request still outstanding.
- **Acceptance** (IDLE or RESP, `req_i`=1, `flush_i`=0):
  - If size is illegal: pulse `illegal_o` next cycle and return to IDLE. No cache request.
  - Else if misaligned: pulse `misaligned_o` next cycle and return to IDLE. No cache request.
  - If both illegal and misaligned, only `illegal_o` fires.
  - Otherwise: register address, lanes and `wren`, then enter BUSY.
- **Byte enables:**
  - byte: `4'b0001` << `addr[1:0]`
  - half: `4'b0011` << `addr[1:0]`
  - word: `4'b1111`
- **BUSY:**
  - `mem_req_o`=1 and the registered `mem_*` outputs stay stable.
  - The timeout counter increments each cycle.
  - On `mem_done_i`: go to RESP. For loads, capture `mem_rdata_i` shifted by the registered offset.
  - On timeout with no done: pulse `bus_error_o`, drop `mem_req_o`, go to IDLE.
  - If `mem_done_i` and timeout coincide, done wins.
- **RESP:**
  - Loads pulse `rdata_valid_o`. Stores produce no pulse.
  - `stall_o`=0.
  - Next state is IDLE, or BUSY if a new request is accepted.
- **Flush:**
  - `flush_i` in BUSY: go to DRAIN. `mem_req_o` stays high; the bus is never aborted.
  - DRAIN: the done is consumed silently (no `rdata_valid_o`), then IDLE. Timeout still applies in DRAIN and raises `bus_error_o`.
  - `flush_i` in IDLE/RESP: blocks acceptance and suppresses any RESP `rdata_valid_o`.
- **Reset:** from any state, return to IDLE and zero every output and register. An in-flight cache access is abandoned, since the cache shares `reset_i`.

## Timing
- Reset values: all outputs 0. `rdata_o`=0 and `mem_addr_o`=0.
- Accept in cycle N → `mem_req_o`=1 from N+1.
- `mem_done_i` sampled in cycle M ≥ N+1 → RESP in M+1, with `rdata_valid_o`=1 and `stall_o`=0. Minimum load latency: 2 cycles from accept to data.
- `stall_o` is combinational:
  - 1 in the accepting cycle when the request is legal.
  - 1 throughout BUSY and DRAIN.
  - 0 in IDLE/RESP otherwise.
  - 0 on illegal/misaligned requests.
- Back-to-back: a request presented in the RESP cycle is accepted, giving one op per 2 cycles with a zero-wait cache.
- `rdata_o` holds its last value until the next capture.

## Structure
- Shared package:
  - state encoding (2 bits)
  - size constants mapping to the existing `RV32I_FUNC3_LOAD_*`/store func3 defines
  - timeout counter width `$clog2(TIMEOUT_CYCLES+1)`
- Sub-module `memory_lane_align`: combinational. Produces byte enables, store-data left shift, read-data right shift and the misalign check from size and `addr[1:0]`.

## Test plan
- Load word at 0x100, done at cycle N+3:
  - `mem_req_o` is high on N+1..N+3.
  - `mem_addr_o`=0x100 and `mem_ben_o`=1111.
  - `rdata_valid_o` pulses at N+4 with `mem_rdata_i` unchanged.
  - `stall_o` is high on N..N+3.
- Store byte 0xA5 to 0x203:
  - `mem_addr_o`=0x200, `mem_ben_o`=1000, `mem_wdata_o`=0xA5000000.
  - No `rdata_valid_o`.
- Load half at 0x101: `misaligned_o` pulses at N+1, `mem_req_o` never rises, `stall_o` stays 0. With `func3_i`=3'b011: `illegal_o` pulses instead.
- `TIMEOUT_CYCLES`=4, no done:
  - `bus_error_o` pulses exactly 4 cycles after `mem_req_o` rises.
  - The FSM returns to IDLE.
  - Done coinciding with expiry yields RESP, not an error.
- `flush_i` on the 2nd BUSY cycle, done 3 cycles later: `mem_req_o` is held until done, `rdata_valid_o` stays 0, and a new request is accepted the cycle after.
- `reset_i` asserted mid-BUSY: the next cycle shows all outputs 0 and state IDLE. A subsequent load completes normally.

Source files
------------

// File: rtl/stage4_memory_sequencer_pkg.sv
// Shared types and constants for the stage-4 load/store sequencer.
// No logic; state encoding, access-size codes and counter sizing only.
package stage4_memory_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Load and store func3 codes share the same low two bits for size.
    localparam logic [2:0] RV32I_FUNC3_LOAD_LB = 3'b000;
    localparam logic [2:0] RV32I_FUNC3_LOAD_LH = 3'b001;
    localparam logic [2:0] RV32I_FUNC3_LOAD_LW = 3'b010;

    localparam logic [1:0] SIZE_BYTE = RV32I_FUNC3_LOAD_LB[1:0];
    localparam logic [1:0] SIZE_HALF = RV32I_FUNC3_LOAD_LH[1:0];
    localparam logic [1:0] SIZE_WORD = RV32I_FUNC3_LOAD_LW[1:0];
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    function automatic int tmo_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/stage4_memory_sequencer_memory_lane_align.sv
// Byte-lane steering: enables, store shift, load shift and misalign check.
// Purely combinational, zero latency; no flow control of its own.
module memory_lane_align
    import stage4_memory_sequencer_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_wr_off,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_rd_off,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_ben,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    always_comb begin
        o_ben        = 4'b0000;
        o_misaligned = 1'b0;
        case (i_size)
            SIZE_BYTE: o_ben = 4'b0001 << i_wr_off;
            SIZE_HALF: begin
                o_ben        = 4'b0011 << i_wr_off;
                o_misaligned = i_wr_off[0];
            end
            SIZE_WORD: begin
                o_ben        = 4'b1111;
                o_misaligned = |i_wr_off;
            end
            default: o_ben = 4'b0000;
        endcase
    end

    assign o_wdata = i_wdata << {i_wr_off, 3'b000};
    assign o_rdata = i_rdata >> {i_rd_off, 3'b000};

endmodule

// File: rtl/stage4_memory_sequencer.sv
// Single-outstanding load/store sequencer between stage 3 and the data cache.
// Accept->req next cycle, done->result next cycle; stall_o holds upstream while busy.
module stage4_memory_sequencer
    import stage4_memory_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        wren_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic        mem_wren_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_ben_o,
    input  logic        mem_done_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misaligned_o,
    output logic        illegal_o,
    output logic        bus_error_o
);

    localparam int               CNT_W    = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wren;
    logic [1:0]       r_off;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic [3:0]       r_ben;
    logic             r_illegal;
    logic             r_misaligned;
    logic             r_bus_error;

    logic        w_busy;
    logic        w_timeout;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_load;
    logic        w_capture;
    logic        w_flag_ill;
    logic        w_flag_mis;
    logic        w_flag_berr;
    logic [3:0]  w_ben;
    logic [31:0] w_wdata_sh;
    logic [31:0] w_rdata_sh;
    logic        w_unused;

    // Sign/zero extension is chosen downstream, so func3 bit 2 is not needed here.
    assign w_unused = &{1'b0, func3_i[2]};

    memory_lane_align u_align (
        .i_size       (func3_i[1:0]),
        .i_wr_off     (addr_i[1:0]),
        .i_wdata      (wdata_i),
        .i_rd_off     (r_off),
        .i_rdata      (mem_rdata_i),
        .o_ben        (w_ben),
        .o_wdata      (w_wdata_sh),
        .o_rdata      (w_rdata_sh),
        .o_misaligned (w_misaligned)
    );

    assign w_illegal = (func3_i[1:0] == SIZE_ILL);
    assign w_busy    = (r_state == ST_BUSY) || (r_state == ST_DRAIN);
    assign w_timeout = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_flag_ill  = 1'b0;
        w_flag_mis  = 1'b0;
        w_flag_berr = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                w_state_nxt = ST_IDLE;
                if (req_i && !flush_i) begin
                    if (w_illegal) begin
                        w_flag_ill = 1'b1;
                    end else if (w_misaligned) begin
                        w_flag_mis = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // Done beats timeout; a flush landing with done discards the result.
                if (mem_done_i) begin
                    w_state_nxt = flush_i ? ST_IDLE : ST_RESP;
                    w_capture   = !flush_i && !r_wren;
                end else if (w_timeout) begin
                    w_flag_berr = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (flush_i) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_done_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_flag_berr = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_cnt        <= '0;
            r_wren       <= 1'b0;
            r_off        <= 2'b00;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_rdata      <= 32'h0;
            r_ben        <= 4'h0;
            r_illegal    <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_illegal    <= w_flag_ill;
            r_misaligned <= w_flag_mis;
            r_bus_error  <= w_flag_berr;
            if (w_load) begin
                r_addr  <= {addr_i[31:2], 2'b00};
                r_ben   <= w_ben;
                r_wdata <= w_wdata_sh;
                r_wren  <= wren_i;
                r_off   <= addr_i[1:0];
                r_cnt   <= '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_rdata <= w_rdata_sh;
            end
        end
    end

    assign mem_req_o     = w_busy;
    assign mem_wren_o    = r_wren;
    assign mem_addr_o    = r_addr;
    assign mem_wdata_o   = r_wdata;
    assign mem_ben_o     = r_ben;
    assign stall_o       = w_busy || w_load;
    assign rdata_o       = r_rdata;
    assign rdata_valid_o = (r_state == ST_RESP) && !r_wren && !flush_i;
    assign misaligned_o  = r_misaligned;
    assign illegal_o     = r_illegal;
    assign bus_error_o   = r_bus_error;

endmodule

// File: tb/tb_stage4_memory_sequencer.sv
// Bench for stage4_memory_sequencer: two instances (timeouts 8 and 4) share stimulus;
// directed literal checks first, then randomized traffic against a transaction model.
module tb_stage4_memory_sequencer;

    localparam int TMO0 = 8;
    localparam int TMO1 = 4;

    logic        clk = 1'b0;
    logic        reset_i, req_i, wren_i, flush_i, mem_done_i;
    logic [2:0]  func3_i;
    logic [31:0] addr_i, wdata_i, mem_rdata_i;

    wire [1:0]       d_req, d_wren, d_stall, d_rv, d_mis, d_ill, d_berr;
    wire [1:0][31:0] d_addr, d_wdata, d_rdata;
    wire [1:0][3:0]  d_ben;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        stage4_memory_sequencer #(.TIMEOUT_CYCLES(g == 0 ? TMO0 : TMO1)) u_dut (
            .clock_i       (clk),
            .reset_i       (reset_i),
            .req_i         (req_i),
            .wren_i        (wren_i),
            .func3_i       (func3_i),
            .addr_i        (addr_i),
            .wdata_i       (wdata_i),
            .flush_i       (flush_i),
            .mem_req_o     (d_req[g]),
            .mem_wren_o    (d_wren[g]),
            .mem_addr_o    (d_addr[g]),
            .mem_wdata_o   (d_wdata[g]),
            .mem_ben_o     (d_ben[g]),
            .mem_done_i    (mem_done_i),
            .mem_rdata_i   (mem_rdata_i),
            .stall_o       (d_stall[g]),
            .rdata_o       (d_rdata[g]),
            .rdata_valid_o (d_rv[g]),
            .misaligned_o  (d_mis[g]),
            .illegal_o     (d_ill[g]),
            .bus_error_o   (d_berr[g])
        );
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d got=%h want=%h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding op record per instance.
    logic        m_out   [2] = '{default: 1'b0};
    logic        m_fl    [2] = '{default: 1'b0};
    logic        m_resp  [2] = '{default: 1'b0};
    logic        m_rload [2] = '{default: 1'b0};
    int          m_wait  [2] = '{default: 0};
    logic [1:0]  m_off   [2] = '{default: 2'b00};
    logic [31:0] e_addr  [2] = '{default: 32'h0};
    logic [31:0] e_wdata [2] = '{default: 32'h0};
    logic [31:0] e_rdata [2] = '{default: 32'h0};
    logic [3:0]  e_ben   [2] = '{default: 4'h0};
    logic        e_wren  [2] = '{default: 1'b0};
    logic        e_ill   [2] = '{default: 1'b0};
    logic        e_mis   [2] = '{default: 1'b0};
    logic        e_berr  [2] = '{default: 1'b0};

    function automatic logic rule_mis(input logic [1:0] sz, input logic [1:0] off);
        return (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
    endfunction

    function automatic logic [3:0] rule_ben(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 4'(1 << off);
            2'd1:    return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int   tmo;
            logic acc, legal, x_stall, x_rv;
            tmo     = (k == 0) ? TMO0 : TMO1;
            acc     = !m_out[k] && req_i && !flush_i;
            legal   = (func3_i[1:0] != 2'd3) && !rule_mis(func3_i[1:0], addr_i[1:0]);
            x_stall = m_out[k] || (acc && legal);
            x_rv    = m_resp[k] && m_rload[k] && !flush_i;
            chk("mem_req_o",     k, 32'(d_req[k]),   32'(m_out[k]));
            chk("mem_wren_o",    k, 32'(d_wren[k]),  32'(e_wren[k]));
            chk("mem_addr_o",    k, d_addr[k],       e_addr[k]);
            chk("mem_wdata_o",   k, d_wdata[k],      e_wdata[k]);
            chk("mem_ben_o",     k, 32'(d_ben[k]),   32'(e_ben[k]));
            chk("stall_o",       k, 32'(d_stall[k]), 32'(x_stall));
            chk("rdata_o",       k, d_rdata[k],      e_rdata[k]);
            chk("rdata_valid_o", k, 32'(d_rv[k]),    32'(x_rv));
            chk("misaligned_o",  k, 32'(d_mis[k]),   32'(e_mis[k]));
            chk("illegal_o",     k, 32'(d_ill[k]),   32'(e_ill[k]));
            chk("bus_error_o",   k, 32'(d_berr[k]),  32'(e_berr[k]));

            if (reset_i) begin
                m_out[k] = 0; m_fl[k] = 0; m_resp[k] = 0; m_rload[k] = 0; m_wait[k] = 0;
                m_off[k] = 0; e_addr[k] = 0; e_wdata[k] = 0; e_rdata[k] = 0; e_ben[k] = 0;
                e_wren[k] = 0; e_ill[k] = 0; e_mis[k] = 0; e_berr[k] = 0;
            end else begin
                e_ill[k] = 0; e_mis[k] = 0; e_berr[k] = 0; m_resp[k] = 0;
                if (m_out[k]) begin
                    if (mem_done_i) begin
                        m_out[k] = 0;
                        if (!m_fl[k] && !flush_i) begin
                            m_resp[k]  = 1;
                            m_rload[k] = !e_wren[k];
                            if (!e_wren[k]) e_rdata[k] = mem_rdata_i >> (8 * m_off[k]);
                        end
                    end else if (m_wait[k] + 1 == tmo) begin
                        e_berr[k] = 1;
                        m_out[k]  = 0;
                    end else begin
                        m_wait[k]++;
                        if (flush_i) m_fl[k] = 1;
                    end
                end else if (acc) begin
                    if (func3_i[1:0] == 2'd3) e_ill[k] = 1;
                    else if (!legal) e_mis[k] = 1;
                    else begin
                        m_out[k]   = 1;
                        m_fl[k]    = 0;
                        m_wait[k]  = 0;
                        m_off[k]   = addr_i[1:0];
                        e_addr[k]  = addr_i & 32'hFFFF_FFFC;
                        e_ben[k]   = rule_ben(func3_i[1:0], addr_i[1:0]);
                        e_wdata[k] = wdata_i << (8 * addr_i[1:0]);
                        e_wren[k]  = wren_i;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_i = 1'b1; wren_i = wr; func3_i = f3; addr_i = a; wdata_i = wd;
    endtask

    task automatic chk_zero(input string tag, input int k);
        chk({tag, "_req"},   k, 32'(d_req[k]),   32'd0);
        chk({tag, "_wren"},  k, 32'(d_wren[k]),  32'd0);
        chk({tag, "_addr"},  k, d_addr[k],       32'd0);
        chk({tag, "_wdata"}, k, d_wdata[k],      32'd0);
        chk({tag, "_ben"},   k, 32'(d_ben[k]),   32'd0);
        chk({tag, "_stall"}, k, 32'(d_stall[k]), 32'd0);
        chk({tag, "_rdata"}, k, d_rdata[k],      32'd0);
        chk({tag, "_rv"},    k, 32'(d_rv[k]),    32'd0);
        chk({tag, "_mis"},   k, 32'(d_mis[k]),   32'd0);
        chk({tag, "_ill"},   k, 32'(d_ill[k]),   32'd0);
        chk({tag, "_berr"},  k, 32'(d_berr[k]),  32'd0);
    endtask

    initial begin
        reset_i = 1'b1; req_i = 1'b0; wren_i = 1'b0; func3_i = 3'd0; addr_i = 32'h0;
        wdata_i = 32'h0; flush_i = 1'b0; mem_done_i = 1'b0; mem_rdata_i = 32'h0;
        cyc(); cyc();
        @(negedge clk); chk_zero("reset", 0);

        // Load word at 0x100, done on the third busy cycle
        cyc(); reset_i = 1'b0; op(1'b0, 3'b010, 32'h100, 32'h0);
        @(negedge clk); chk("ldw_stall_n", 0, 32'(d_stall[0]), 32'd1);
        cyc(); req_i = 1'b0;
        @(negedge clk);
        chk("ldw_req_n1", 0, 32'(d_req[0]), 32'd1);
        chk("ldw_addr", 0, d_addr[0], 32'h100);
        chk("ldw_ben", 0, 32'(d_ben[0]), 32'hF);
        chk("ldw_stall_n1", 0, 32'(d_stall[0]), 32'd1);
        cyc(); @(negedge clk); chk("ldw_req_n2", 0, 32'(d_req[0]), 32'd1);
        cyc(); mem_done_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        @(negedge clk);
        chk("ldw_req_n3", 0, 32'(d_req[0]), 32'd1);
        chk("ldw_stall_n3", 0, 32'(d_stall[0]), 32'd1);
        cyc(); mem_done_i = 1'b0;
        @(negedge clk);
        chk("ldw_rv_n4", 0, 32'(d_rv[0]), 32'd1);
        chk("ldw_rdata", 0, d_rdata[0], 32'hDEADBEEF);
        chk("ldw_stall_n4", 0, 32'(d_stall[0]), 32'd0);
        chk("ldw_req_n4", 0, 32'(d_req[0]), 32'd0);

        // Store byte 0xA5 to 0x203 with a zero-wait cache
        cyc(); op(1'b1, 3'b000, 32'h203, 32'h0000_00A5);
        @(negedge clk); chk("sb_stall", 0, 32'(d_stall[0]), 32'd1);
        cyc(); req_i = 1'b0; mem_done_i = 1'b1;
        @(negedge clk);
        chk("sb_addr", 0, d_addr[0], 32'h200);
        chk("sb_ben", 0, 32'(d_ben[0]), 32'h8);
        chk("sb_wdata", 0, d_wdata[0], 32'hA500_0000);
        chk("sb_wren", 0, 32'(d_wren[0]), 32'd1);
        cyc(); mem_done_i = 1'b0;
        @(negedge clk);
        chk("sb_rv", 0, 32'(d_rv[0]), 32'd0);
        chk("sb_rdata_hold", 0, d_rdata[0], 32'hDEADBEEF);

        // Misaligned half, then illegal size at the same address
        cyc(); op(1'b0, 3'b001, 32'h101, 32'h0);
        @(negedge clk); chk("mis_stall", 0, 32'(d_stall[0]), 32'd0);
        cyc(); req_i = 1'b0;
        @(negedge clk);
        chk("mis_pulse", 0, 32'(d_mis[0]), 32'd1);
        chk("mis_req", 0, 32'(d_req[0]), 32'd0);
        chk("mis_ill", 0, 32'(d_ill[0]), 32'd0);
        cyc(); op(1'b0, 3'b011, 32'h101, 32'h0);
        @(negedge clk); chk("ill_stall", 0, 32'(d_stall[0]), 32'd0);
        cyc(); req_i = 1'b0;
        @(negedge clk);
        chk("ill_pulse", 0, 32'(d_ill[0]), 32'd1);
        chk("ill_mis", 0, 32'(d_mis[0]), 32'd0);
        chk("ill_req", 0, 32'(d_req[0]), 32'd0);

        // Timeout on the 4-cycle instance: error 4 cycles after req rises
        cyc(); op(1'b0, 3'b010, 32'h300, 32'h0);
        cyc(); req_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("tmo_req_held", 1, 32'(d_req[1]), 32'd1);
            chk("tmo_no_err_yet", 1, 32'(d_berr[1]), 32'd0);
            cyc();
        end
        mem_done_i = 1'b1;
        @(negedge clk);
        chk("tmo_berr", 1, 32'(d_berr[1]), 32'd1);
        chk("tmo_req_drop", 1, 32'(d_req[1]), 32'd0);
        chk("tmo_stall", 1, 32'(d_stall[1]), 32'd0);
        cyc(); mem_done_i = 1'b0;
        @(negedge clk); chk("tmo_berr_pulse", 1, 32'(d_berr[1]), 32'd0);

        // Done coinciding with expiry wins
        cyc(); op(1'b0, 3'b010, 32'h304, 32'h0);
        cyc(); req_i = 1'b0;
        cyc(); cyc();
        cyc(); mem_done_i = 1'b1; mem_rdata_i = 32'h1122_3344;
        @(negedge clk); chk("coin_req", 1, 32'(d_req[1]), 32'd1);
        cyc(); mem_done_i = 1'b0;
        @(negedge clk);
        chk("coin_rv", 1, 32'(d_rv[1]), 32'd1);
        chk("coin_berr", 1, 32'(d_berr[1]), 32'd0);
        chk("coin_rdata", 1, d_rdata[1], 32'h1122_3344);

        // Flush on the second busy cycle, done three cycles later
        cyc(); op(1'b0, 3'b010, 32'h400, 32'h0);
        cyc(); req_i = 1'b0;
        cyc(); flush_i = 1'b1;
        @(negedge clk); chk("fl_stall", 0, 32'(d_stall[0]), 32'd1);
        cyc(); flush_i = 1'b0;
        @(negedge clk); chk("fl_req_a", 0, 32'(d_req[0]), 32'd1);
        cyc();
        @(negedge clk); chk("fl_req_b", 0, 32'(d_req[0]), 32'd1);
        cyc(); mem_done_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk); chk("fl_req_c", 0, 32'(d_req[0]), 32'd1);
        cyc(); mem_done_i = 1'b0; op(1'b0, 3'b010, 32'h404, 32'h0);
        @(negedge clk);
        chk("fl_rv", 0, 32'(d_rv[0]), 32'd0);
        chk("fl_req_off", 0, 32'(d_req[0]), 32'd0);
        chk("fl_accept_stall", 0, 32'(d_stall[0]), 32'd1);
        cyc(); req_i = 1'b0;
        @(negedge clk);
        chk("fl_next_req", 0, 32'(d_req[0]), 32'd1);
        chk("fl_next_addr", 0, d_addr[0], 32'h404);
        cyc(); mem_done_i = 1'b1;
        cyc(); mem_done_i = 1'b0;
        @(negedge clk);
        chk("fl_next_rv", 0, 32'(d_rv[0]), 32'd1);
        chk("fl_next_rdata", 0, d_rdata[0], 32'hCAFE_F00D);

        // Reset mid-busy, then a byte load at offset 3
        cyc(); op(1'b0, 3'b000, 32'h503, 32'h0);
        cyc(); req_i = 1'b0;
        cyc(); reset_i = 1'b1;
        cyc(); reset_i = 1'b0;
        @(negedge clk); chk_zero("midrst", 0);
        cyc(); op(1'b0, 3'b000, 32'h503, 32'h0);
        @(negedge clk); chk("postrst_stall", 0, 32'(d_stall[0]), 32'd1);
        cyc(); req_i = 1'b0; mem_done_i = 1'b1; mem_rdata_i = 32'h89AB_CDEF;
        @(negedge clk);
        chk("postrst_req", 0, 32'(d_req[0]), 32'd1);
        chk("postrst_ben", 0, 32'(d_ben[0]), 32'h8);
        chk("postrst_addr", 0, d_addr[0], 32'h500);
        cyc(); mem_done_i = 1'b0;
        @(negedge clk);
        chk("postrst_rv", 0, 32'(d_rv[0]), 32'd1);
        chk("postrst_rdata", 0, d_rdata[0], 32'h0000_0089);

        // Randomized traffic; the compare process checks every cycle
        for (int c = 0; c < 3000; c++) begin
            cyc();
            reset_i     = ($urandom_range(0, 199) == 0);
            req_i       = 1'($urandom_range(0, 1));
            wren_i      = 1'($urandom_range(0, 1));
            func3_i     = 3'($urandom_range(0, 7));
            addr_i      = $urandom;
            if ($urandom_range(0, 1) == 1) addr_i[1:0] = 2'b00;
            wdata_i     = $urandom;
            mem_rdata_i = $urandom;
            flush_i     = ($urandom_range(0, 15) == 0);
            mem_done_i  = (d_req != 2'b00) && ($urandom_range(0, 2) == 0);
        end
        cyc();
        reset_i = 1'b0; req_i = 1'b0; flush_i = 1'b0; mem_done_i = 1'b0;
        cyc();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
